// File: rtl/sim_pkg.sv
// Purpose: shared encodings for the run controller and its trace ring.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sim_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_HOLD = 2'b01,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } run_state_t;

    typedef enum logic [1:0] {
        ST_NONE    = 2'b00,
        ST_HALT    = 2'b01,
        ST_TIMEOUT = 2'b10,
        ST_LOOP    = 2'b11
    } status_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/sim_run_ctrl_trace_ring.sv
// Purpose: circular FIFO that keeps the newest DEPTH records, overwriting the oldest when full.
// Latency: push visible at head one cycle later; head data is a combinational read.
// Backpressure: never stalls the writer; a full push drops the oldest entry and sets ovf.
module trace_ring #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 8
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic             clr,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             head_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic             ovf
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_nxt;
    logic             do_pop;
    logic             full;
    logic             overwrite;

    always_comb begin
        do_pop    = pop_rdy && (occ != '0);
        full      = (occ == OCC_W'(DEPTH));
        overwrite = push_vld && full && !do_pop;
        occ_nxt   = occ;
        if (push_vld && !do_pop && !full) begin
            occ_nxt = occ + OCC_W'(1);
        end else if (do_pop && !push_vld) begin
            occ_nxt = occ - OCC_W'(1);
        end
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            head_vld <= 1'b0;
            ovf      <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            head_vld <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            // An overwrite retires the oldest entry exactly like a pop would.
            if (do_pop || overwrite) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (overwrite) begin
                ovf <= 1'b1;
            end
            occ      <= occ_nxt;
            head_vld <= (occ_nxt != '0);
        end
    end

    always_ff @(posedge core_clk) begin
        if (push_vld && !clr) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/sim_run_ctrl.sv
// Purpose: sequences the core reset, bounds a run (halt/loop/timeout), counts and traces retirements.
// Latency: control and counters registered one cycle after the event; trace_pc/trace_inst are combinational.
// Backpressure: none on writeback; the trace ring overwrites its oldest entry when full.
module sim_run_ctrl
    import sim_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RST_HOLD    = 2,
    parameter int unsigned TIMEOUT     = 50,
    parameter int unsigned LOOP_LIMIT  = 16,
    parameter int unsigned TRACE_DEPTH = 8,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             cpu_rst,
    input  logic             halt,
    input  logic             wb_valid,
    input  logic [XLEN-1:0]  wb_pc,
    input  logic [XLEN-1:0]  wb_inst,
    input  logic             trace_rd,
    output logic             trace_valid,
    output logic [XLEN-1:0]  trace_pc,
    output logic [XLEN-1:0]  trace_inst,
    output logic             trace_ovf,
    output logic             running,
    output logic             done,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count
);
    localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
    localparam int unsigned LEN_W  = $clog2(LOOP_LIMIT + 1);

    run_state_t       state;
    status_t          status_q;
    status_t          term;
    logic [HOLD_W-1:0] hold_cnt;
    logic [XLEN-1:0]  last_pc;
    logic [LEN_W-1:0] run_len;
    logic [LEN_W-1:0] len_nxt;
    logic             tracked;
    logic             in_run;
    logic             retire;
    logic             loop_hit;
    logic             timeout_hit;
    logic             accept_start;

    always_comb begin
        in_run       = (state == S_RUN);
        retire       = in_run && wb_valid;
        accept_start = start && ((state == S_IDLE) || (state == S_DONE));
        // tracked forces the first retirement of a run to restart the length at 1.
        if (tracked && (wb_pc == last_pc)) begin
            len_nxt = (run_len == LEN_W'(LOOP_LIMIT)) ? run_len : run_len + LEN_W'(1);
        end else begin
            len_nxt = LEN_W'(1);
        end
        loop_hit    = retire && (len_nxt == LEN_W'(LOOP_LIMIT));
        timeout_hit = in_run && (cycle_count == CNT_W'(TIMEOUT - 1));
        term        = ST_NONE;
        if (in_run && halt) begin
            term = ST_HALT;
        end else if (loop_hit) begin
            term = ST_LOOP;
        end else if (timeout_hit) begin
            term = ST_TIMEOUT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            cpu_rst      <= 1'b1;
            running      <= 1'b0;
            done         <= 1'b0;
            status_q     <= ST_NONE;
            cycle_count  <= '0;
            retire_count <= '0;
            hold_cnt     <= '0;
            last_pc      <= '0;
            run_len      <= '0;
            tracked      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept_start) begin
                        state        <= S_HOLD;
                        cpu_rst      <= 1'b1;
                        done         <= 1'b0;
                        status_q     <= ST_NONE;
                        cycle_count  <= '0;
                        retire_count <= '0;
                        hold_cnt     <= '0;
                        last_pc      <= '0;
                        run_len      <= '0;
                        tracked      <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
                        state   <= S_RUN;
                        cpu_rst <= 1'b0;
                        running <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + CNT_W'(1);
                    end
                    if (wb_valid) begin
                        if (retire_count != '1) begin
                            retire_count <= retire_count + CNT_W'(1);
                        end
                        last_pc <= wb_pc;
                        run_len <= len_nxt;
                        tracked <= 1'b1;
                    end
                    if (term != ST_NONE) begin
                        state    <= S_DONE;
                        running  <= 1'b0;
                        done     <= 1'b1;
                        status_q <= term;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign status = status_q;

    trace_ring #(
        .WIDTH (2 * XLEN),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_ring (
        .core_clk (clk),
        .arst_n   (rst),
        .clr      (accept_start),
        .push_vld (retire),
        .push_dat ({wb_pc, wb_inst}),
        .pop_rdy  (trace_rd),
        .head_vld (trace_valid),
        .head_dat ({trace_pc, trace_inst}),
        .ovf      (trace_ovf)
    );

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl: halt, timeout, loop, trace overwrite, pop/push on full, async reset.
module tb_sim_run_ctrl;
    import sim_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic        cpu_rst;
    logic        halt;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [31:0] wb_inst;
    logic        trace_rd;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [31:0] trace_inst;
    logic        trace_ovf;
    logic        running;
    logic        done;
    logic [1:0]  status;
    logic [31:0] cycle_count;
    logic [31:0] retire_count;

    int errors = 0;
    int checks = 0;

    sim_run_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cpu_rst      (cpu_rst),
        .halt         (halt),
        .wb_valid     (wb_valid),
        .wb_pc        (wb_pc),
        .wb_inst      (wb_inst),
        .trace_rd     (trace_rd),
        .trace_valid  (trace_valid),
        .trace_pc     (trace_pc),
        .trace_inst   (trace_inst),
        .trace_ovf    (trace_ovf),
        .running      (running),
        .done         (done),
        .status       (status),
        .cycle_count  (cycle_count),
        .retire_count (retire_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_start();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] inst);
        wb_valid = 1'b1;
        wb_pc    = pc;
        wb_inst  = inst;
        step();
        wb_valid = 1'b0;
    endtask

    initial begin
        start = 0; halt = 0; wb_valid = 0; wb_pc = 0; wb_inst = 0; trace_rd = 0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #6;
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_status", status, 0);
        chk("rst_cycle", cycle_count, 0);
        chk("rst_retire", retire_count, 0);
        chk("rst_tvalid", trace_valid, 0);
        chk("rst_ovf", trace_ovf, 0);
        rst = 1'b1;
        step();
        chk("idle_cpu_rst", cpu_rst, 1);

        // 1: reset hold length, then 5 retirements and halt on RUN cycle 10
        start = 1'b1;
        step();
        start = 1'b0;
        chk("hold1_cpu_rst", cpu_rst, 1);
        step();
        chk("hold2_cpu_rst", cpu_rst, 1);
        chk("hold2_running", running, 0);
        step();
        chk("run_cpu_rst", cpu_rst, 0);
        chk("run_running", running, 1);
        for (int i = 0; i < 5; i++) retire(32'h100 + 4 * i, NOP_INST);
        repeat (4) step();
        chk("t1_cycle9", cycle_count, 9);
        chk("t1_done_early", done, 0);
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("t1_status", status, 1);
        chk("t1_cycle", cycle_count, 10);
        chk("t1_retire", retire_count, 5);
        chk("t1_done", done, 1);
        chk("t1_running", running, 0);
        chk("t1_head_pc", trace_pc, 32'h100);
        chk("t1_head_inst", trace_inst, 32'h13);
        trace_rd = 1'b1;
        step();
        trace_rd = 1'b0;
        chk("t1_pop_pc", trace_pc, 32'h104);
        step();
        chk("t1_frozen_cycle", cycle_count, 10);

        // 2: timeout with no halt or retirements; start from DONE clears state
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t2_clr_status", status, 0);
        chk("t2_clr_done", done, 0);
        chk("t2_clr_cycle", cycle_count, 0);
        chk("t2_clr_tvalid", trace_valid, 0);
        chk("t2_cpu_rst", cpu_rst, 1);
        step();
        step();
        repeat (49) step();
        chk("t2_cycle49", cycle_count, 49);
        chk("t2_done49", done, 0);
        step();
        chk("t2_status", status, 2);
        chk("t2_cycle", cycle_count, 50);
        chk("t2_retire", retire_count, 0);
        chk("t2_done", done, 1);
        repeat (3) step();
        chk("t2_cpu_rst_done", cpu_rst, 0);
        chk("t2_cycle_frozen", cycle_count, 50);

        // 3: LOOP on the 16th same-pc retirement; broken run does not flag
        run_start();
        for (int i = 0; i < 16; i++) begin
            retire(32'h40, 32'h0000_006F);
            if (i == 14) chk("t3_no_loop15", done, 0);
        end
        chk("t3_status", status, 3);
        chk("t3_retire", retire_count, 16);
        chk("t3_cycle", cycle_count, 16);
        run_start();
        for (int i = 0; i < 15; i++) retire(32'h40, 32'h6F);
        retire(32'h44, 32'h6F);
        for (int i = 0; i < 15; i++) retire(32'h40, 32'h6F);
        chk("t3b_done", done, 0);
        chk("t3b_status", status, 0);
        chk("t3b_retire", retire_count, 31);
        repeat (19) step();
        chk("t3b_timeout", status, 2);

        // 4: 12 retirements into an 8-deep ring, then drain
        run_start();
        for (int i = 0; i < 12; i++) begin
            retire(4 * i, i);
            if (i == 7) chk("t4_ovf_at_full", trace_ovf, 0);
        end
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("t4_status", status, 1);
        chk("t4_ovf", trace_ovf, 1);
        for (int i = 0; i < 8; i++) begin
            chk("t4_tvalid", trace_valid, 1);
            chk("t4_pc", trace_pc, 32'h10 + 4 * i);
            chk("t4_inst", trace_inst, 4 + i);
            trace_rd = 1'b1;
            step();
            trace_rd = 1'b0;
        end
        chk("t4_empty", trace_valid, 0);
        trace_rd = 1'b1;
        step();
        trace_rd = 1'b0;
        chk("t4_pop_empty", trace_valid, 0);

        // 5: halt beats LOOP in the same cycle; pop+push on full does not overflow
        run_start();
        for (int i = 0; i < 15; i++) retire(32'h80, NOP_INST);
        halt = 1'b1;
        retire(32'h80, NOP_INST);
        halt = 1'b0;
        chk("t5_status", status, 1);
        chk("t5_retire", retire_count, 16);
        run_start();
        for (int i = 0; i < 8; i++) retire(32'h200 + 4 * i, NOP_INST);
        trace_rd = 1'b1;
        retire(32'h220, NOP_INST);
        trace_rd = 1'b0;
        chk("t5_popwr_ovf", trace_ovf, 0);
        chk("t5_popwr_head", trace_pc, 32'h204);
        retire(32'h224, NOP_INST);
        chk("t5_full_ovf", trace_ovf, 1);
        chk("t5_full_head", trace_pc, 32'h208);
        halt = 1'b1;
        step();
        halt = 1'b0;

        // 6: asynchronous reset mid-run, then restart from DONE
        run_start();
        retire(32'h300, NOP_INST);
        retire(32'h304, NOP_INST);
        chk("t6_pre_cycle", cycle_count, 2);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_cpu_rst", cpu_rst, 1);
        chk("t6_async_cycle", cycle_count, 0);
        chk("t6_async_retire", retire_count, 0);
        chk("t6_async_running", running, 0);
        chk("t6_async_tvalid", trace_valid, 0);
        rst = 1'b1;
        step();
        run_start();
        for (int i = 0; i < 3; i++) retire(32'h400 + 4 * i, NOP_INST);
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("t6_done", done, 1);
        chk("t6_tvalid", trace_valid, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t6_restart_tvalid", trace_valid, 0);
        chk("t6_restart_status", status, 0);
        chk("t6_restart_cpu_rst", cpu_rst, 1);
        step();
        step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("t6_final_cycle", cycle_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
